// File: rtl/redun_to_canonical.sv
// Redundant-coefficient to canonical integer converter: word-serial carry
// resolution followed by restoring shift-subtract reduction modulo MODULUS.
module redun_to_canonical #(
    parameter int                              WORD_BITS       = 16,
    parameter int                              NUM_WORDS       = 64,
    parameter logic [WORD_BITS*NUM_WORDS-1:0]  MODULUS         = '0,
    parameter int                              REDUN_WORD_BITS = 1,
    parameter int                              I_WORD          = NUM_WORDS + 1,
    parameter int                              COEF_BITS       = WORD_BITS + REDUN_WORD_BITS
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_val,
    output logic                            o_rdy,
    input  logic [I_WORD*COEF_BITS-1:0]     i_dat,
    output logic                            o_val,
    input  logic                            i_rdy,
    output logic [NUM_WORDS*WORD_BITS-1:0]  o_dat
);

    localparam int ACC_BITS   = WORD_BITS*I_WORD + REDUN_WORD_BITS + 1;
    localparam int MOD_BITS   = $clog2({1'b0, MODULUS} + 1);
    localparam int SHIFTS     = ACC_BITS - MOD_BITS;
    localparam int CMP_BITS   = ACC_BITS + SHIFTS;
    localparam int CARRY_BITS = REDUN_WORD_BITS + 1;
    localparam int KW         = $clog2(I_WORD + 1);
    localparam int JW         = $clog2(SHIFTS + 1);

    localparam logic [KW-1:0] K_LAST = KW'(I_WORD);
    localparam logic [JW-1:0] J_TOP  = JW'(SHIFTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CARRY,
        S_REDUCE,
        S_DONE
    } state_t;

    state_t                          r_state;
    logic [I_WORD*COEF_BITS-1:0]     r_dat;
    logic [CARRY_BITS-1:0]           r_carry;
    logic [KW-1:0]                   r_k;
    logic [JW-1:0]                   r_j;
    // Held at compare width so the shifted modulus never needs truncating.
    logic [CMP_BITS-1:0]             r_acc;

    logic [COEF_BITS:0]              w_sum;
    logic [CMP_BITS-1:0]             w_mod_sh;
    logic                            w_ge;
    logic [CMP_BITS-1:0]             w_acc_red;

    assign w_sum     = {1'b0, r_dat[COEF_BITS-1:0]} + (COEF_BITS+1)'(r_carry);
    assign w_mod_sh  = CMP_BITS'(MODULUS) << r_j;
    assign w_ge      = (r_acc >= w_mod_sh);
    assign w_acc_red = w_ge ? (r_acc - w_mod_sh) : r_acc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_dat   <= '0;
            r_carry <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            o_rdy   <= 1'b1;
            o_val   <= 1'b0;
            o_dat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_val && o_rdy) begin
                        r_dat   <= i_dat;
                        r_carry <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        o_rdy   <= 1'b0;
                        r_state <= S_CARRY;
                    end
                end
                S_CARRY: begin
                    if (r_k == K_LAST) begin
                        // Leftover carry lands above the top coefficient word.
                        r_acc[ACC_BITS-1 -: CARRY_BITS] <= r_carry;
                        r_j     <= J_TOP;
                        r_state <= S_REDUCE;
                    end else begin
                        r_acc[r_k*WORD_BITS +: WORD_BITS] <= w_sum[WORD_BITS-1:0];
                        r_carry <= w_sum[COEF_BITS:WORD_BITS];
                        r_dat   <= r_dat >> COEF_BITS;
                        r_k     <= r_k + 1'b1;
                    end
                end
                S_REDUCE: begin
                    r_acc <= w_acc_red;
                    if (r_j == '0) begin
                        o_dat   <= w_acc_red[NUM_WORDS*WORD_BITS-1:0];
                        o_val   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_j <= r_j - 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_rdy) begin
                        o_val   <= 1'b0;
                        o_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
